// File: rtl/cla_result_accumulator.sv
// rtl/cla_result_accumulator.sv - sums COUNT adder results per block and hands off the block total
//
// Purpose
//   Takes one carry-lookahead adder result per valid/ready beat.
//   Adds COUNT results into a wide accumulator.
//   Presents the block total downstream and holds it until it is accepted.
//
// Ports
//   i_clk       in   1          clock, rising edge
//   i_rst_n     in   1          asynchronous active-low reset
//   i_valid     in   1          upstream result valid
//   o_ready     out  1          block can accept a result (ACCUM state)
//   i_result    in   WIDTH+1    adder result {carry, sum}, unsigned
//   i_clear     in   1          synchronous abort of partial or held block
//   o_valid     out  1          block total available (HOLD state)
//   i_ready     in   1          downstream accepts the total
//   o_sum       out  ACC_WIDTH  accumulator / block total
//   o_count     out  CNT_WIDTH  results accepted in current block
//   o_overflow  out  1          sticky accumulator wrap flag for current block

module cla_result_accumulator #(
    parameter int WIDTH     = 14,
    parameter int COUNT     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int ACC_WIDTH = 18
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH:0]       i_result,
    input  logic                 i_clear,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_overflow
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   emit;
    logic                   last_beat;
    // One extra bit so the carry out of the accumulator MSB is visible.
    logic [ACC_WIDTH:0]     add_sum;

    assign accept    = i_valid && (state_q == ST_ACCUM);
    assign emit      = i_ready && (state_q == ST_HOLD);
    assign last_beat = (cnt_q == CNT_WIDTH'(COUNT - 1));
    assign add_sum   = {1'b0, acc_q} + {{(ACC_WIDTH - WIDTH){1'b0}}, i_result};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // Clear outranks both the input accept and the output handshake.
        if (i_clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            acc_d = add_sum[ACC_WIDTH-1:0];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            ovf_d = ovf_q | add_sum[ACC_WIDTH];
            if (last_beat) begin
                state_d = ST_HOLD;
            end
        end else if (emit) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only, so they never depend on inputs.
    assign o_ready    = (state_q == ST_ACCUM);
    assign o_valid    = (state_q == ST_HOLD);
    assign o_sum      = acc_q;
    assign o_count    = cnt_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_cla_result_accumulator.sv
// tb/tb_cla_result_accumulator.sv - self-checking bench for cla_result_accumulator

module tb_cla_result_accumulator;

    logic        clk;
    logic        rst_n;

    logic        v0, rdy0, clr0;
    logic [14:0] res0;
    logic        ordy0, oval0, oovf0;
    logic [17:0] osum0;
    logic [3:0]  ocnt0;

    logic        v1, rdy1, clr1;
    logic [14:0] res1;
    logic        ordy1, oval1, oovf1;
    logic [14:0] osum1;
    logic [3:0]  ocnt1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [17:0] exp_acc;
    logic [3:0]  exp_cnt;
    logic        exp_ovf;
    logic [18:0] sb_q[$];

    cla_result_accumulator u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(ordy0),
        .i_result(res0), .i_clear(clr0), .o_valid(oval0), .i_ready(rdy0),
        .o_sum(osum0), .o_count(ocnt0), .o_overflow(oovf0)
    );

    cla_result_accumulator #(.WIDTH(14), .COUNT(2), .CNT_WIDTH(4), .ACC_WIDTH(15)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(ordy1),
        .i_result(res1), .i_clear(clr1), .o_valid(oval1), .i_ready(rdy1),
        .o_sum(osum1), .o_count(ocnt1), .o_overflow(oovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_acc = '0;
        exp_cnt = '0;
        exp_ovf = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge so beats run back-to-back.
    task automatic beat(input logic [14:0] val);
        int n;
        logic [18:0] s;
        v0 = 1'b1;
        res0 = val;
        n = 0;
        while (!ordy0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 32'(ordy0), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        res0 = 'x;
        s = {1'b0, exp_acc} + {4'd0, val};
        exp_acc = s[17:0];
        exp_ovf = exp_ovf | s[18];
        exp_cnt = exp_cnt + 4'd1;
        chk("beat_count", 32'(ocnt0), 32'(exp_cnt));
        if (exp_cnt == 4'd8) begin
            chk("valid_latency", 32'(oval0), 32'd1);
            sb_q.push_back({exp_ovf, exp_acc});
            model_reset();
        end else begin
            chk("valid_low_mid_block", 32'(oval0), 32'd0);
        end
    endtask

    task automatic idle(input int cycles);
        logic [3:0] c;
        c = ocnt0;
        repeat (cycles) begin
            v0 = 1'b0;
            res0 = 'x;
            @(posedge clk); #1;
        end
        chk("bubble_count_hold", 32'(ocnt0), 32'(c));
    endtask

    task automatic collect();
        int n;
        logic [18:0] e;
        n = 0;
        while (!oval0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("total_valid", 32'(oval0), 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        chk("total_sum", 32'(osum0), 32'(e[17:0]));
        chk("total_overflow", 32'(oovf0), 32'(e[18]));
        chk("total_count", 32'(ocnt0), 32'd8);
        rdy0 = 1'b1;
        @(posedge clk); #1;
        rdy0 = 1'b0;
        chk("post_emit_valid", 32'(oval0), 32'd0);
        chk("post_emit_ready", 32'(ordy0), 32'd1);
        chk("post_emit_sum", 32'(osum0), 32'd0);
        chk("post_emit_count", 32'(ocnt0), 32'd0);
    endtask

    initial begin
        logic [17:0] held;
        rst_n = 1'b0;
        v0 = 1'b0; rdy0 = 1'b0; clr0 = 1'b0; res0 = '0;
        v1 = 1'b0; rdy1 = 1'b0; clr1 = 1'b0; res1 = '0;
        model_reset();
        #12;
        chk("reset_sum", 32'(osum0), 32'd0);
        chk("reset_count", 32'(ocnt0), 32'd0);
        chk("reset_valid", 32'(oval0), 32'd0);
        chk("reset_overflow", 32'(oovf0), 32'd0);
        chk("reset_ready", 32'(ordy0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: eight back-to-back max-value beats
        for (int i = 0; i < 8; i++) beat(15'h7FFF);
        chk("t1_sum_const", 32'(osum0), 32'h3FFF8);
        collect();

        // 2: values 1..8 with random bubbles, including X on i_result while idle
        for (int i = 1; i <= 8; i++) begin
            idle($urandom_range(0, 2));
            beat(15'(i));
        end
        chk("t2_sum_const", 32'(osum0), 32'd36);
        collect();

        // 3: backpressure in HOLD with i_valid held high
        for (int i = 0; i < 8; i++) beat(15'h0100);
        held = osum0;
        chk("t3_held_const", 32'(held), 32'h0800);
        v0 = 1'b1;
        res0 = 15'h0055;
        rdy0 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("t3_hold_valid", 32'(oval0), 32'd1);
            chk("t3_hold_ready", 32'(ordy0), 32'd0);
            chk("t3_hold_sum", 32'(osum0), 32'(held));
            chk("t3_hold_count", 32'(ocnt0), 32'd8);
        end
        v0 = 1'b0;
        collect();

        // 4: partial block aborted by clear with a beat offered in the same cycle
        for (int i = 0; i < 3; i++) beat(15'd5);
        chk("t4_partial_sum", 32'(osum0), 32'd15);
        clr0 = 1'b1;
        v0 = 1'b1;
        res0 = 15'd5;
        @(posedge clk); #1;
        clr0 = 1'b0;
        v0 = 1'b0;
        model_reset();
        chk("t4_clear_count", 32'(ocnt0), 32'd0);
        chk("t4_clear_sum", 32'(osum0), 32'd0);
        chk("t4_clear_ready", 32'(ordy0), 32'd1);
        for (int i = 0; i < 8; i++) beat(15'd2);
        chk("t4_sum_const", 32'(osum0), 32'd16);
        collect();

        // 5: narrow accumulator wraps; overflow clears for the next block
        chk("t5_ready", 32'(ordy1), 32'd1);
        v1 = 1'b1;
        res1 = 15'h7FFF;
        @(posedge clk); #1;
        chk("t5_count1", 32'(ocnt1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("t5_valid", 32'(oval1), 32'd1);
        chk("t5_sum", 32'(osum1), 32'h7FFE);
        chk("t5_overflow", 32'(oovf1), 32'd1);
        rdy1 = 1'b1;
        @(posedge clk); #1;
        rdy1 = 1'b0;
        chk("t5_emit_valid", 32'(oval1), 32'd0);
        chk("t5_emit_overflow", 32'(oovf1), 32'd0);
        v1 = 1'b1;
        res1 = 15'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("t5b_valid", 32'(oval1), 32'd1);
        chk("t5b_sum", 32'(osum1), 32'd2);
        chk("t5b_overflow", 32'(oovf1), 32'd0);

        // 6: asynchronous reset while holding a total
        for (int i = 0; i < 8; i++) beat(15'd1);
        chk("t6_hold_valid", 32'(oval0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(oval0), 32'd0);
        chk("t6_rst_count", 32'(ocnt0), 32'd0);
        chk("t6_rst_sum", 32'(osum0), 32'd0);
        chk("t6_rst_ready", 32'(ordy0), 32'd1);
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_after_ready", 32'(ordy0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
